// File: rtl/rename_regfile_if.sv
// Handshake bundle between ID/ROB and the rename register file.
// master: ID/ROB side, slave: register file side.
interface rename_regfile_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int TAGW = 5,
  parameter int NRD  = 2,
  parameter int CW   = 6
);
  logic                 rdy;
  logic                 flush;
  logic                 se;
  logic [AW-1:0]        saddr;
  logic [TAGW-1:0]      stag;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [TAGW-1:0]      wtag;
  logic [XLEN-1:0]      wdata;
  logic [NRD-1:0]       re;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD*TAGW-1:0]  rtag;
  logic [NRD-1:0]       rrdy;
  logic [CW-1:0]        pending_cnt;

  modport master (
    output rdy, flush, se, saddr, stag,
    output we, waddr, wtag, wdata, re, raddr,
    input  rdata, rtag, rrdy, pending_cnt
  );

  modport slave (
    input  rdy, flush, se, saddr, stag,
    input  we, waddr, wtag, wdata, re, raddr,
    output rdata, rtag, rrdy, pending_cnt
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, busy bits,
// commit bypass and a registered count of busy registers.
module rename_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int TAGW = 5,
  parameter int NRD  = 2,
  parameter int CW   = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  rename_regfile_if.slave bus
);

  logic [XLEN-1:0] r_val [NREG];
  logic [TAGW-1:0] r_tag [NREG];
  logic [NREG-1:0] r_busy;
  logic [CW-1:0]   r_cnt;

  logic            w_cmt;
  logic            w_alloc;
  logic            w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  assign w_cmt   = bus.we && (bus.waddr != '0);
  assign w_alloc = bus.se && (bus.saddr != '0)
                   && !bus.flush;
  assign w_clr   = w_cmt && r_busy[bus.waddr]
                   && (r_tag[bus.waddr] == bus.wtag);

  // Allocation is applied after the clear so it wins on a collision.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_clr)   w_busy_nxt[bus.waddr] = 1'b0;
      if (w_alloc) w_busy_nxt[bus.saddr] = 1'b1;
    end
    w_cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
      r_busy <= '0;
      r_cnt  <= '0;
    end else if (bus.rdy) begin
      if (w_cmt)   r_val[bus.waddr] <= bus.wdata;
      if (w_alloc) r_tag[bus.saddr] <= bus.stag;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Reads see pre-allocation state; only a live commit is bypassed.
  always_comb begin
    logic [AW-1:0] w_a;
    bus.rdata = '0;
    bus.rtag  = '0;
    bus.rrdy  = '0;
    for (int i = 0; i < NRD; i++) begin
      w_a = bus.raddr[i*AW +: AW];
      if (i_rst || bus.flush || !bus.re[i]) begin
        bus.rrdy[i] = 1'b0;
      end else if (w_a == '0) begin
        bus.rrdy[i] = 1'b1;
      end else if (bus.we && (bus.waddr == w_a)
                   && r_busy[w_a]
                   && (r_tag[w_a] == bus.wtag)) begin
        bus.rdata[i*XLEN +: XLEN] = bus.wdata;
        bus.rrdy[i] = 1'b1;
      end else begin
        bus.rdata[i*XLEN +: XLEN] = r_val[w_a];
        bus.rtag[i*TAGW +: TAGW]  = r_tag[w_a];
        bus.rrdy[i] = !r_busy[w_a];
      end
    end
  end

  assign bus.pending_cnt = r_cnt;

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename tags and busy tracking for the out-of-order core.
- Sits between ID (operand lookup, destination allocation) and ROB (in-order commit).
- Generalises the two-port 32x32 file:
  - configurable width, depth, tag width and read-port count;
  - busy-qualified commit bypass;
  - x0 protection on allocation;
  - registered pending-register counter.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
AW, 5, register address width, equal to log2(NREG)
TAGW, 5, ROB tag width
NRD, 2, number of read ports
CW, 6, pending counter width, equal to clog2(NREG+1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0, no state changes
flush  in  1  misprediction flush from ROB
se  in  1  allocate destination (ID)
saddr  in  AW  destination register being allocated
stag  in  TAGW  ROB tag of the allocating instruction
we  in  1  commit write (ROB)
waddr  in  AW  commit destination register
wtag  in  TAGW  ROB tag of the committing instruction
wdata  in  XLEN  commit value
re  in  NRD  per-port read enable
raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rtag  out  NRD*TAGW  producer tag when not ready
rrdy  out  NRD  operand-ready flag
pending_cnt  out  CW  number of busy registers (registered)

Behaviour:
- State: val[NREG] (XLEN bits), tag[NREG] (TAGW bits), busy[NREG] (1 bit), cnt (CW bits).
- Reset (rst high at posedge, takes priority over everything):
  - val, tag and busy all cleared to 0; cnt cleared to 0.
  - While rst is high, all read outputs are 0, including rrdy.
- rdy=0: hold all state. Read outputs remain combinationally valid.
- Commit, when we && waddr!=0:
  - val[waddr] <= wdata unconditionally.
  - busy[waddr] is cleared only if busy[waddr] && tag[waddr]==wtag and no same-cycle allocation targets waddr.
  - A stale commit (tag mismatch) writes the value but leaves busy/tag untouched.
- Allocate, when se && saddr!=0 && !flush:
  - tag[saddr] <= stag; busy[saddr] <= 1.
  - Allocation to x0 is ignored.
  - Simultaneous allocate and commit to the same register: allocation wins (busy=1, new tag); the value is still written.
- Flush:
  - All busy bits cleared next cycle; tags retained but meaningless; cnt <= 0.
  - A commit in the same cycle still writes val.
  - Allocation in the same cycle is dropped.
  - While flush is high, read outputs are 0 with rrdy=0.
- Read port i is combinational. Priority, first match wins:
  1. rst || flush: data 0, tag 0, rrdy 0.
  2. !re[i]: data 0, tag 0, rrdy 0.
  3. raddr==0: data 0, tag 0, rrdy 1.
  4. we && waddr==raddr && busy[waddr] && tag[waddr]==wtag: data wdata, tag 0, rrdy 1 (commit bypass).
  5. Otherwise: data val[raddr], tag tag[raddr], rrdy !busy[raddr].
- A same-cycle allocation does not affect reads. Reads see pre-allocation state, because sources precede the destination in program order.
- pending_cnt:
  - cnt <= popcount of next-state busy vector; output is the registered cnt.
  - Latency is 1 cycle after the causing edge.
  - Never exceeds NREG-1, since x0 is never busy.
- Ports are independent. Any combination of identical addresses across ports returns identical results.

Test Plan:
- Reset then read x5 on port 0 with re=1 -> rdata=0, rrdy=1, rtag=0; pending_cnt=0.
- Allocate x3 with tag 7, then the next cycle read x3 -> rrdy=0, rtag=7, pending_cnt=1. Commit x3 with tag 7 and data 0xDEADBEEF, reading x3 in the same cycle -> rdata=0xDEADBEEF, rrdy=1. Next cycle -> val=0xDEADBEEF, rrdy=1, pending_cnt=0.
- Allocate x4 with tag 2, then allocate x4 with tag 9, then commit x4 with tag 2 and data 0x11 -> x4 reads data 0x11, rrdy=0, rtag=9. Commit with tag 9 and data 0x22 -> rrdy=1, data 0x22.
- Same cycle: allocate x6 with tag 3 and commit x6 with its matching old tag 1, data 0x55 -> read of x6 in that cycle bypasses 0x55 with rrdy=1. Next cycle -> rrdy=0, rtag=3, data 0x55.
- Allocate x1, x2 and x8, then flush while committing x8 with data 0xAB and allocating x9 -> outputs 0 during flush. Next cycle -> all rrdy=1, x8=0xAB, x9 not busy, pending_cnt=0.
- Allocate x0, and commit x0 with data 0xFF -> x0 reads 0 with rrdy=1, pending_cnt unchanged. Repeat with rdy=0 on allocate and commit -> no state change.
